bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential double-dabble converter: binary value in, packed BCD digits out.
//  It sits directly upstream of the seven-segment driver and feeds its 16-bit digit bus.
//  It does one shift/correct iteration per clock, so no wide combinational adder chain is needed.
//  The output stays stable between conversions, so the display never shows a partial result.
// PARAMETERS
//  IN_W     16    binary input width; one iteration per bit
//  DIGITS   4     BCD digits produced; bcd width = 4*DIGITS
//  OVF_CODE 4'hF  nibble written into every digit when the result does not fit in DIGITS
//  AUTO     1     1: free-running, start is ignored and a conversion launches whenever idle
//                 0: conversions launch only on start
// PORTS
//  clk    in   1           system clock, rising edge
//  rst    in   1           asynchronous reset, active high
//  bin    in   IN_W        binary value, sampled only on the launch edge
//  start  in   1           launch request, sampled in IDLE only (AUTO=0)
//  busy   out  1           conversion in progress
//  done   out  1           one-cycle pulse; bcd/ovf updated on the same edge
//  bcd    out  4*DIGITS    packed BCD, digit 0 in [3:0]; held between conversions
//  ovf    out  1           last result exceeded 10^DIGITS-1; held with bcd
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is asynchronous, active high.
//    While rst is high: state=IDLE, busy=0, done=0, bcd=0, ovf=0, internal regs cleared.
//  - States:
//    IDLE:  busy=0. Launch condition = (AUTO ? 1 : start).
//           On launch: capture bin into shift reg, clear scratch BCD reg and sticky ovf,
//           cnt=0, go to SHIFT.
//    SHIFT: busy=1. Each edge performs one iteration:
//           (a) every scratch digit >=5 gets +3;
//           (b) {scratch, binreg} shifts left by 1;
//           (c) the bit shifted out of the scratch MSB is ORed into sticky ovf.
//           cnt increments. On the edge where cnt==IN_W-1, the final iteration result is
//           loaded into bcd (or {DIGITS{OVF_CODE}} if ovf), ovf is loaded, done<=1,
//           busy<=0, state goes to IDLE.
//  - Timing: launch at edge E0; iterations at edges E1..E_IN_W.
//    bcd, ovf and done are valid after edge E_IN_W (16 cycles with the defaults).
//    done is high for exactly one cycle. That cycle is IDLE, so a new launch may occur on the
//    next edge. AUTO=1 gives a period of IN_W+1 cycles.
//  - start while busy is ignored and not queued. bin changes during SHIFT have no effect.
//  - Overflow: sticky ovf captures the carry out of the top digit (result >= 10^DIGITS).
//    The corrected digits are computed per digit from 4-bit values.
//    IN_W=16, DIGITS=4: 0..9999 convert exactly; 10000..65535 give ovf=1, bcd=16'hFFFF.
//  - bcd/ovf change only on a done edge or on reset. cnt width = clog2(IN_W).
//  - Reset mid-SHIFT aborts the conversion. After release: IDLE, bcd=0, no done pulse.
//  - AUTO=1 after reset release: the first launch happens on the first edge.
// TESTING
//  1. AUTO=0, bin=16'd1234, 1-cycle start -> busy for 16 cycles; done pulse;
//     bcd=16'h1234, ovf=0.
//  2. bin=0 -> bcd=16'h0000, ovf=0.
//     bin=9999 -> bcd=16'h9999, ovf=0.
//  3. bin=10000 -> ovf=1, bcd=16'hFFFF.
//     bin=65535 -> ovf=1, bcd=16'hFFFF.
//     Then bin=42 -> ovf=0, bcd=16'h0042.
//  4. start pulsed at cycle 5 of a conversion (bin changed to 7) -> ignored;
//     first result unaffected, no second done.
//  5. rst asserted at iteration 8 of a conversion of 5555 -> bcd=0, busy=0 immediately;
//     no done after release.
//  6. AUTO=1, bin stepped 0->321->9876 -> done every 17 cycles;
//     bcd tracks each value within two periods.
//     Random sweep vs reference model: exact match, ovf iff bin>9999.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift/correct iteration per clock.
// The result and overflow flag are held stable between conversions and update only on the done edge.
module bin_to_bcd_seq #(
    parameter int         IN_W     = 16,
    parameter int         DIGITS   = 4,
    parameter logic [3:0] OVF_CODE = 4'hF,
    parameter bit         AUTO     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [IN_W-1:0]  binreg;
    logic [BW-1:0]    scratch;
    logic             ovf_s;
    logic [CNT_W-1:0] cnt;

    logic [BW-1:0]    corr;
    logic [BW-1:0]    scratch_nxt;
    logic             ovf_nxt;
    logic             launch;
    logic             last_iter;

    // Correction is done per 4-bit digit; a digit >= 5 doubles into the next decade after +3.
    always_comb begin
        corr = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                corr[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_nxt = {corr[BW-2:0], binreg[IN_W-1]};
        ovf_nxt     = ovf_s | corr[BW-1];
    end

    assign launch    = AUTO ? 1'b1 : start;
    assign last_iter = (cnt == CNT_W'(IN_W - 1));
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            binreg  <= '0;
            scratch <= '0;
            ovf_s   <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        binreg  <= bin;
                        scratch <= '0;
                        ovf_s   <= 1'b0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    binreg  <= binreg << 1;
                    ovf_s   <= ovf_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd   <= ovf_nxt ? {DIGITS{OVF_CODE}} : scratch_nxt;
                        ovf   <= ovf_nxt;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
